// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
// Bundles the fetch port, the load/store data port and the Memory-side bus
// that memory_arbiter sits between.
//
// Signal summary:
//   ifReq/ifAddress          fetch request and byte address (core -> arbiter)
//   ifData/ifAck/ifError     fetched word, completion pulse, fault flag
//   dReq/dWrite/dAddress     data request, direction (1 = store), byte address
//   dWriteData               store data (core -> arbiter)
//   dReadData/dAck/dError    load result, completion pulse, fault flag
//   memEnable/memAddress     access strobe and address (arbiter -> Memory)
//   memReadWrite             1 = write (arbiter -> Memory)
//   memWriteData             store data (arbiter -> Memory)
//   memReadData              read data (Memory -> arbiter)
//
// Modports:
//   slave  - the arbiter's view
//   master - the view of whatever drives the requests and models Memory
interface memory_arbiter_if;

    logic        ifReq;
    logic [31:0] ifAddress;
    logic [31:0] ifData;
    logic        ifAck;
    logic        ifError;

    logic        dReq;
    logic        dWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;
    logic        dAck;
    logic        dError;

    logic        memEnable;
    logic [31:0] memAddress;
    logic        memReadWrite;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    modport slave (
        input  ifReq, ifAddress,
        input  dReq, dWrite, dAddress, dWriteData,
        input  memReadData,
        output ifData, ifAck, ifError,
        output dReadData, dAck, dError,
        output memEnable, memAddress, memReadWrite, memWriteData
    );

    modport master (
        output ifReq, ifAddress,
        output dReq, dWrite, dAddress, dWriteData,
        output memReadData,
        input  ifData, ifAck, ifError,
        input  dReadData, dAck, dError,
        input  memEnable, memAddress, memReadWrite, memWriteData
    );

endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares the unified Memory (ROM when address[10]==0, RAM when address[10]==1)
// between the instruction-fetch port and the load/store data port. One access
// is in flight at a time; under contention the ports are served round-robin.
// A legal access holds the Memory inputs stable for LATENCY cycles, captures
// read data on the last of them, then pulses the granted port's ack. Misaligned
// accesses and ROM writes are answered with ack+error one cycle after the grant
// and never enable Memory.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high; returns to IDLE and clears all outputs
//   bus    - memory_arbiter_if.slave carrying both request ports and the
//            Memory-side bus
//
// Parameter:
//   LATENCY - cycles Memory needs with stable inputs (1..15)
module memory_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    memory_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        FAULT
    } arbState_e;

    typedef enum logic {
        PORT_FETCH,
        PORT_DATA
    } port_e;

    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    arbState_e   state;
    arbState_e   stateNext;

    port_e       grant;
    port_e       lastGrant;
    port_e       grantPort;
    logic        grantValid;
    logic        grantIllegal;

    logic [31:0] selAddress;
    logic        selWrite;

    logic [31:0] latAddress;
    logic        latWrite;
    logic [31:0] latWriteData;
    logic [3:0]  count;

    logic [31:0] ifDataReg;
    logic [31:0] dReadDataReg;

    // Next-state logic. In IDLE this also picks the port to grant: a lone
    // request wins outright, and when both are pending the port that did not
    // win last time goes first. The legality check looks at the candidate
    // port's address and direction so the FSM can skip straight to FAULT.
    always_comb begin
        stateNext    = state;
        grantValid   = 1'b0;
        grantPort    = PORT_FETCH;
        grantIllegal = 1'b0;
        selAddress   = bus.ifAddress;
        selWrite     = 1'b0;

        if (bus.ifReq && bus.dReq) begin
            grantPort = (lastGrant == PORT_DATA) ? PORT_FETCH : PORT_DATA;
        end else if (bus.dReq) begin
            grantPort = PORT_DATA;
        end

        if (grantPort == PORT_DATA) begin
            selAddress = bus.dAddress;
            selWrite   = bus.dWrite;
        end

        grantIllegal = (selAddress[1:0] != 2'b00) || (selWrite && !selAddress[10]);

        case (state)
            IDLE: begin
                if (bus.ifReq || bus.dReq) begin
                    grantValid = 1'b1;
                    stateNext  = grantIllegal ? FAULT : ACCESS;
                end
            end
            ACCESS: begin
                if (count == 4'd0) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            FAULT:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Grant bookkeeping and datapath. A grant latches everything Memory needs
    // so the Memory inputs stay stable for the whole access even if the
    // requester changes or drops its inputs. lastGrant starts at DATA so that
    // fetch wins the first contention after reset. Read data is captured only
    // on the final ACCESS cycle and only for reads, so a store or a fault
    // leaves the port's data register untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant        <= PORT_FETCH;
            lastGrant    <= PORT_DATA;
            latAddress   <= '0;
            latWrite     <= 1'b0;
            latWriteData <= '0;
            count        <= '0;
            ifDataReg    <= '0;
            dReadDataReg <= '0;
        end else if (grantValid) begin
            grant        <= grantPort;
            lastGrant    <= grantPort;
            latAddress   <= selAddress;
            latWrite     <= selWrite;
            latWriteData <= (grantPort == PORT_DATA) ? bus.dWriteData : '0;
            count        <= COUNT_LOAD;
        end else if (state == ACCESS) begin
            if (count == 4'd0) begin
                if (!latWrite) begin
                    if (grant == PORT_DATA) begin
                        dReadDataReg <= bus.memReadData;
                    end else begin
                        ifDataReg <= bus.memReadData;
                    end
                end
            end else begin
                count <= count - 4'd1;
            end
        end
    end

    // Every output is decoded from registered state only, so nothing on the
    // request inputs reaches Memory or the acks combinationally. The write
    // strobe is qualified by ACCESS so a faulted store never presents a write.
    assign bus.memEnable    = (state == ACCESS);
    assign bus.memAddress   = latAddress;
    assign bus.memReadWrite = (state == ACCESS) && latWrite;
    assign bus.memWriteData = latWriteData;

    assign bus.ifAck   = ((state == DONE) || (state == FAULT)) && (grant == PORT_FETCH);
    assign bus.ifError = (state == FAULT) && (grant == PORT_FETCH);
    assign bus.dAck    = ((state == DONE) || (state == FAULT)) && (grant == PORT_DATA);
    assign bus.dError  = (state == FAULT) && (grant == PORT_DATA);

    assign bus.ifData    = ifDataReg;
    assign bus.dReadData = dReadDataReg;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed bench for memory_arbiter. Two instances (LATENCY=2 and LATENCY=1)
// share the same request/Memory stimulus; sel1 chooses which one is observed.
// Each scenario task drives its own vectors and checks against hand-computed
// values cycle by cycle.
module tb_memory_arbiter;

    logic clk;
    logic reset;
    logic sel1;

    logic        ifReq;
    logic [31:0] ifAddress;
    logic        dReq;
    logic        dWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] memReadData;

    logic [31:0] ifData;
    logic        ifAck;
    logic        ifError;
    logic [31:0] dReadData;
    logic        dAck;
    logic        dError;
    logic        memEnable;
    logic [31:0] memAddress;
    logic        memReadWrite;
    logic [31:0] memWriteData;
    logic [5:0]  ctl;

    int checks;
    int errors;

    memory_arbiter_if bus2 ();
    memory_arbiter_if bus1 ();

    memory_arbiter #(.LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    memory_arbiter #(.LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // Both instances see identical stimulus.
    assign bus2.ifReq       = ifReq;
    assign bus2.ifAddress   = ifAddress;
    assign bus2.dReq        = dReq;
    assign bus2.dWrite      = dWrite;
    assign bus2.dAddress    = dAddress;
    assign bus2.dWriteData  = dWriteData;
    assign bus2.memReadData = memReadData;
    assign bus1.ifReq       = ifReq;
    assign bus1.ifAddress   = ifAddress;
    assign bus1.dReq        = dReq;
    assign bus1.dWrite      = dWrite;
    assign bus1.dAddress    = dAddress;
    assign bus1.dWriteData  = dWriteData;
    assign bus1.memReadData = memReadData;

    // Observed outputs come from whichever instance is under test.
    always_comb begin
        ifData       = sel1 ? bus1.ifData       : bus2.ifData;
        ifAck        = sel1 ? bus1.ifAck        : bus2.ifAck;
        ifError      = sel1 ? bus1.ifError      : bus2.ifError;
        dReadData    = sel1 ? bus1.dReadData    : bus2.dReadData;
        dAck         = sel1 ? bus1.dAck         : bus2.dAck;
        dError       = sel1 ? bus1.dError       : bus2.dError;
        memEnable    = sel1 ? bus1.memEnable    : bus2.memEnable;
        memAddress   = sel1 ? bus1.memAddress   : bus2.memAddress;
        memReadWrite = sel1 ? bus1.memReadWrite : bus2.memReadWrite;
        memWriteData = sel1 ? bus1.memWriteData : bus2.memWriteData;
    end

    assign ctl = {memEnable, memReadWrite, ifAck, ifError, dAck, dError};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifReq = 1'b0; ifAddress = '0; dReq = 1'b0; dWrite = 1'b0;
        dAddress = '0; dWriteData = '0; memReadData = '0;
        reset = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({ctl, memAddress, memWriteData, ifData, dReadData} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs c=%0d: got ctl=%b addr=%h wd=%h if=%h d=%h expected all zero",
                         c, ctl, memAddress, memWriteData, ifData, dReadData);
            end
            if (c < 2) tick();
        end
        reset = 1'b0;
        tick();
        checks++;
        if (ctl !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL reset_idle: got ctl=%b expected 000000", ctl);
        end
    endtask

    task automatic test_read(input int lat);
        ifReq = 1'b1; ifAddress = 32'h0000_0004; dReq = 1'b0;
        memReadData = 32'hBAD0_0000;
        for (int c = 1; c <= lat + 2; c++) begin
            tick();
            memReadData = (c == lat) ? 32'h0010_0093 : (32'hBAD0_0000 | 32'(c));
            checks++;
            if (ctl !== {c <= lat, 1'b0, c == lat + 1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL read_ctl L=%0d c=%0d: got %b expected %b",
                         lat, c, ctl, {c <= lat, 1'b0, c == lat + 1, 1'b0, 1'b0, 1'b0});
            end
            if (c <= lat) begin
                checks++;
                if (memAddress !== 32'h0000_0004) begin
                    errors++;
                    $display("[TB] FAIL read_addr L=%0d c=%0d: got %h expected 00000004", lat, c, memAddress);
                end
            end
            if (c >= lat + 1) begin
                checks++;
                if (ifData !== 32'h0010_0093) begin
                    errors++;
                    $display("[TB] FAIL read_data L=%0d c=%0d: got %h expected 00100093", lat, c, ifData);
                end
            end
            if (c == lat + 1) ifReq = 1'b0;
        end
    endtask

    task automatic test_store();
        dReq = 1'b1; dWrite = 1'b1; dAddress = 32'h0000_0408;
        dWriteData = 32'hDEAD_BEEF; memReadData = 32'h5555_AAAA;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (ctl !== {c <= 2, c <= 2, 1'b0, 1'b0, c == 3, 1'b0}) begin
                errors++;
                $display("[TB] FAIL store_ctl c=%0d: got %b expected %b",
                         c, ctl, {c <= 2, c <= 2, 1'b0, 1'b0, c == 3, 1'b0});
            end
            if (c <= 2) begin
                checks++;
                if ({memAddress, memWriteData} !== {32'h0000_0408, 32'hDEAD_BEEF}) begin
                    errors++;
                    $display("[TB] FAIL store_bus c=%0d: got addr=%h wd=%h expected 00000408/deadbeef",
                             c, memAddress, memWriteData);
                end
            end
            if (c == 3) begin
                checks++;
                if (dReadData !== 32'h0) begin
                    errors++;
                    $display("[TB] FAIL store_rdata: got %h expected 00000000", dReadData);
                end
                dReq = 1'b0; dWrite = 1'b0;
            end
        end
    endtask

    task automatic test_illegal();
        // A legal load first gives dReadData a known value.
        dReq = 1'b1; dWrite = 1'b0; dAddress = 32'h0000_0404; memReadData = 32'h1234_5678;
        for (int c = 1; c <= 3; c++) tick();
        checks++;
        if ({dAck, dError, dReadData} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            errors++;
            $display("[TB] FAIL load_ack: got ack=%b err=%b data=%h expected 1/0/12345678",
                     dAck, dError, dReadData);
        end
        dReq = 1'b0;
        tick();

        // ROM store
        dReq = 1'b1; dWrite = 1'b1; dAddress = 32'h0000_0010;
        dWriteData = 32'hFFFF_0000; memReadData = 32'h9999_9999;
        tick();
        checks++;
        if ({ctl, dReadData} !== {6'b000011, 32'h1234_5678}) begin
            errors++;
            $display("[TB] FAIL rom_store: got ctl=%b data=%h expected 000011/12345678", ctl, dReadData);
        end
        dReq = 1'b0; dWrite = 1'b0;
        tick();
        checks++;
        if (ctl !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL rom_store_after: got %b expected 000000", ctl);
        end

        // Misaligned load
        dReq = 1'b1; dAddress = 32'h0000_0402;
        tick();
        checks++;
        if ({ctl, dReadData} !== {6'b000011, 32'h1234_5678}) begin
            errors++;
            $display("[TB] FAIL misaligned_load: got ctl=%b data=%h expected 000011/12345678", ctl, dReadData);
        end
        dReq = 1'b0;
        tick();

        // Misaligned fetch
        ifReq = 1'b1; ifAddress = 32'h0000_0001;
        tick();
        checks++;
        if ({ctl, ifData} !== {6'b001100, 32'h0010_0093}) begin
            errors++;
            $display("[TB] FAIL misaligned_fetch: got ctl=%b data=%h expected 001100/00100093", ctl, ifData);
        end
        ifReq = 1'b0;
        tick();
        checks++;
        if (ctl !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL misaligned_fetch_after: got %b expected 000000", ctl);
        end
    endtask

    task automatic test_contention(input int lat);
        int per;
        int p;
        int g;
        logic fetchTurn;
        logic [5:0] expCtl;
        per = lat + 2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ifReq = 1'b1; ifAddress = 32'h0000_0008;
        dReq = 1'b1; dWrite = 1'b0; dAddress = 32'h0000_040C;
        memReadData = 32'h1000_0000;
        for (int c = 1; c <= 4 * per; c++) begin
            tick();
            memReadData = 32'h1000_0000 + 32'(c);
            p = c % per;
            g = c / per;
            fetchTurn = (g % 2 == 0);
            expCtl = {(p >= 1) && (p <= lat), 1'b0, (p == lat + 1) && fetchTurn, 1'b0,
                      (p == lat + 1) && !fetchTurn, 1'b0};
            checks++;
            if (ctl !== expCtl) begin
                errors++;
                $display("[TB] FAIL contend_ctl L=%0d c=%0d: got %b expected %b", lat, c, ctl, expCtl);
            end
            if ((p >= 1) && (p <= lat)) begin
                checks++;
                if (memAddress !== (fetchTurn ? 32'h0000_0008 : 32'h0000_040C)) begin
                    errors++;
                    $display("[TB] FAIL contend_addr L=%0d c=%0d: got %h expected %h", lat, c, memAddress,
                             fetchTurn ? 32'h0000_0008 : 32'h0000_040C);
                end
            end
            if (p == lat + 1) begin
                checks++;
                if ((fetchTurn ? ifData : dReadData) !== 32'h1000_0000 + 32'(c - 1)) begin
                    errors++;
                    $display("[TB] FAIL contend_data L=%0d c=%0d: got %h expected %h", lat, c,
                             fetchTurn ? ifData : dReadData, 32'h1000_0000 + 32'(c - 1));
                end
            end
        end
        ifReq = 1'b0; dReq = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        ifReq = 1'b1; ifAddress = 32'h0000_0008; memReadData = 32'h7777_7777;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if (memEnable !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mid_enable c=%0d: got %b expected 1", c, memEnable);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ctl, memAddress, ifData} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_async: got ctl=%b addr=%h data=%h expected zeros", ctl, memAddress, ifData);
        end
        ifReq = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (ctl !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL mid_no_ack: got %b expected 000000", ctl);
        end
        ifReq = 1'b1; ifAddress = 32'h0000_000C; memReadData = 32'hCAFE_0001;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (ctl !== {c <= 2, 1'b0, c == 3, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL mid_fresh_ctl c=%0d: got %b expected %b",
                         c, ctl, {c <= 2, 1'b0, c == 3, 1'b0, 1'b0, 1'b0});
            end
        end
        checks++;
        if (ifData !== 32'hCAFE_0001) begin
            errors++;
            $display("[TB] FAIL mid_fresh_data: got %h expected cafe0001", ifData);
        end
        ifReq = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sel1 = 1'b0;
        reset = 1'b0;
        ifReq = 1'b0; ifAddress = '0; dReq = 1'b0; dWrite = 1'b0;
        dAddress = '0; dWriteData = '0; memReadData = '0;

        test_reset();
        test_read(2);
        test_store();
        test_illegal();
        test_contention(2);
        test_reset_mid();

        sel1 = 1'b1;
        test_reset();
        test_read(1);
        test_contention(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
